relm_ps2_rx: RTL and testbench

//  Hardware PS/2 receiver for the keyboard port. It filters the raw PS/2 clock and data lines,

---
 rtl/relm_ps2_rx_if.sv | 10 +
 rtl/relm_ps2_rx.sv | 154 +++++++++++++++
 tb/tb_relm_ps2_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/relm_ps2_rx_if.sv
// ReLM pop port for the PS/2 receiver: bit WD is request (pop_d) / retry (pop_q).
interface relm_ps2_rx_if #(
    parameter int WD = 32
);
    logic [WD:0] pop_d;
    logic [WD:0] pop_q;

    modport master (output pop_d, input  pop_q);
    modport slave  (input  pop_d, output pop_q);
endinterface

// File: rtl/relm_ps2_rx.sv
// PS/2 device-to-host receiver: line conditioning, 11-bit frame decode with
// odd parity and timeout, and a byte FIFO read through a ReLM pop port.
module relm_ps2_rx #(
    parameter int WD      = 32,
    parameter int WAF     = 4,
    parameter int NFILT   = 8,
    parameter int TIMEOUT = 50000,
    parameter int WT      = 16
) (
    input  logic           clk,
    input  logic           rst_n_in,
    input  logic           ps2_clk_in,
    input  logic           ps2_dat_in,
    relm_ps2_rx_if.slave   pop
);
    localparam int DEPTH = 1 << WAF;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;
    localparam logic [WT-1:0] TMO = WT'(TIMEOUT);

    logic [1:0]       clk_sync, dat_sync;
    logic [NFILT-1:0] clk_sr, dat_sr;
    logic             clk_f, clk_f_d, dat_f;
    logic             fall;

    logic [1:0]       state;
    logic [2:0]       bit_cnt;
    logic             parity;
    logic [7:0]       shreg;
    logic [WT-1:0]    tcnt;
    logic [7:0]       err_cnt;

    logic [7:0]       mem [DEPTH];
    logic [WAF-1:0]   head, tail;
    logic [WAF:0]     cnt;
    logic             overflow;

    logic timeout, frame_done, frame_good, err_inc;
    logic empty, full, do_pop, do_push, ovf_set;
    logic unused_pop_bits;

    // Filtered levels only move when the whole window agrees; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_sr   <= '1;
            dat_sr   <= '1;
            clk_f    <= 1'b1;
            clk_f_d  <= 1'b1;
            dat_f    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_sr   <= {clk_sr[NFILT-2:0], clk_sync[1]};
            dat_sr   <= {dat_sr[NFILT-2:0], dat_sync[1]};
            if (&clk_sr)       clk_f <= 1'b1;
            else if (~|clk_sr) clk_f <= 1'b0;
            if (&dat_sr)       dat_f <= 1'b1;
            else if (~|dat_sr) dat_f <= 1'b0;
            clk_f_d  <= clk_f;
        end
    end

    assign fall       = clk_f_d & ~clk_f;
    assign timeout    = (state != S_IDLE) && !fall && (tcnt == TMO);
    assign frame_done = fall && (state == S_STOP);
    assign frame_good = frame_done && dat_f && parity;
    assign err_inc    = (frame_done && !(dat_f && parity)) || timeout;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            parity  <= 1'b0;
            shreg   <= '0;
            tcnt    <= '0;
            err_cnt <= '0;
        end else begin
            if (fall) begin
                tcnt <= '0;
                case (state)
                    S_IDLE: if (!dat_f) begin
                        bit_cnt <= '0;
                        parity  <= 1'b0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        shreg   <= {dat_f, shreg[7:1]};
                        parity  <= parity ^ dat_f;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PAR;
                    end
                    S_PAR: begin
                        parity <= parity ^ dat_f;
                        state  <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (timeout) begin
                state <= S_IDLE;
                tcnt  <= '0;
                shreg <= '0;
            end else if (state != S_IDLE) begin
                tcnt <= tcnt + WT'(1);
            end else begin
                tcnt <= '0;
            end
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign empty   = (cnt == '0);
    assign full    = cnt[WAF];
    assign do_pop  = pop.pop_d[WD] && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = frame_good && (!full || do_pop);
    assign ovf_set = frame_good && full && !do_pop;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[tail] <= shreg;
                tail      <= tail + WAF'(1);
            end
            if (do_pop) head <= head + WAF'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (WAF+1)'(1);
                2'b01:   cnt <= cnt - (WAF+1)'(1);
                default: cnt <= cnt;
            endcase
            if (ovf_set)     overflow <= 1'b1;
            else if (do_pop) overflow <= 1'b0;
        end
    end

    always_comb begin
        pop.pop_q        = '0;
        pop.pop_q[WD]    = empty;
        pop.pop_q[23:16] = err_cnt;
        pop.pop_q[8]     = overflow;
        pop.pop_q[7:0]   = mem[head];
    end

    assign unused_pop_bits = ^pop.pop_d[WD-1:0];
endmodule

// File: tb/tb_relm_ps2_rx.sv
// Directed bench for relm_ps2_rx: good/bad frames, glitch, timeout, overflow, reset.
module tb_relm_ps2_rx;
    localparam int WD       = 32;
    localparam int HALF     = 20;
    localparam int TMO      = 300;
    // Sync (2) + filter fill (8) + filtered-level register (1): strobe is live in the 12th cycle.
    localparam int EDGE_LAT = 11;

    logic clk        = 1'b0;
    logic rst_n_in   = 1'b0;
    logic ps2_clk_in = 1'b1;
    logic ps2_dat_in = 1'b1;
    int   total      = 0;
    int   bad        = 0;

    relm_ps2_rx_if #(.WD(WD)) pop_if ();

    relm_ps2_rx #(.WD(WD), .WAF(4), .NFILT(8), .TIMEOUT(TMO), .WT(9)) dut (
        .clk        (clk),
        .rst_n_in   (rst_n_in),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .pop        (pop_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WD:0] obs, input logic [WD:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_retry(input string tag, input logic exp);
        check(tag, (WD+1)'(pop_if.pop_q[WD]), (WD+1)'(exp));
    endtask
    task automatic chk_byte(input string tag, input logic [7:0] exp);
        check(tag, (WD+1)'(pop_if.pop_q[7:0]), (WD+1)'(exp));
    endtask
    task automatic chk_ovf(input string tag, input logic exp);
        check(tag, (WD+1)'(pop_if.pop_q[8]), (WD+1)'(exp));
    endtask
    task automatic chk_err(input string tag, input logic [7:0] exp);
        check(tag, (WD+1)'(pop_if.pop_q[23:16]), (WD+1)'(exp));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic pop_at_edge);
        @(negedge clk);
        ps2_dat_in = b;
        wait_cyc(HALF);
        ps2_clk_in = 1'b0;
        if (pop_at_edge) begin
            wait_cyc(EDGE_LAT);
            pop_if.pop_d[WD] = 1'b1;
            wait_cyc(1);
            pop_if.pop_d[WD] = 1'b0;
            wait_cyc(HALF - EDGE_LAT - 1);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input int nbits,
                              input logic pop_at_stop);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], pop_at_stop && (i == 10));
        if (nbits == 11) begin
            ps2_dat_in = 1'b1;
            wait_cyc(2 * HALF);
        end
    endtask

    task automatic do_pop();
        @(negedge clk);
        pop_if.pop_d[WD] = 1'b1;
        @(negedge clk);
        pop_if.pop_d[WD] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_in = 1'b0;
        wait_cyc(3);
        rst_n_in = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        pop_if.pop_d = '0;
        wait_cyc(3);
        check("reset_q", pop_if.pop_q, {1'b1, 32'h0});
        rst_n_in = 1'b1;
        wait_cyc(5);
        check("post_reset_q", pop_if.pop_q, {1'b1, 32'h0});

        // good frame
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk_retry("t1_retry", 1'b0);
        chk_byte("t1_byte", 8'h1C);
        chk_ovf("t1_ovf", 1'b0);
        chk_err("t1_err", 8'd0);
        do_pop();
        chk_retry("t1_after_pop", 1'b1);

        // bad parity, then a good frame
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        chk_retry("t2_empty", 1'b1);
        chk_err("t2_err", 8'd1);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        chk_retry("t2_retry", 1'b0);
        chk_byte("t2_byte", 8'hF0);
        chk_err("t2_err_hold", 8'd1);
        do_pop();

        // 3-cycle clock glitch with data low must not start a frame
        @(negedge clk);
        ps2_dat_in = 1'b0;
        wait_cyc(HALF);
        ps2_clk_in = 1'b0;
        wait_cyc(3);
        ps2_clk_in = 1'b1;
        wait_cyc(40);
        chk_retry("t3_empty", 1'b1);
        chk_err("t3_err", 8'd1);
        ps2_dat_in = 1'b1;
        wait_cyc(40);
        send_frame(8'h5A, 1'b0, 11, 1'b0);
        chk_retry("t3_retry", 1'b0);
        chk_byte("t3_byte", 8'h5A);
        chk_err("t3_err_after", 8'd1);
        do_pop();

        // timeout after start + 4 data bits
        do_reset();
        send_frame(8'h0F, 1'b0, 5, 1'b0);
        ps2_dat_in = 1'b1;
        wait_cyc(TMO + 10);
        chk_err("t4_err", 8'd1);
        chk_retry("t4_empty", 1'b1);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        chk_retry("t4_retry", 1'b0);
        chk_byte("t4_byte", 8'h29);
        chk_err("t4_err_hold", 8'd1);
        do_pop();

        // overflow: 17th byte with no pop is dropped
        do_reset();
        for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b0, 11, 1'b0);
        chk_byte("t5_head", 8'h01);
        chk_ovf("t5_ovf_before", 1'b0);
        send_frame(8'h11, 1'b0, 11, 1'b0);
        chk_ovf("t5_ovf_set", 1'b1);
        chk_byte("t5_head_kept", 8'h01);
        chk_err("t5_err", 8'd0);
        for (int i = 1; i <= 16; i++) begin
            chk_byte("t5_drain_byte", 8'(i));
            chk_ovf("t5_drain_ovf", (i == 1) ? 1'b1 : 1'b0);
            do_pop();
        end
        chk_retry("t5_empty", 1'b1);

        // overflow: 17th byte coinciding with a pop is accepted
        for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b0, 11, 1'b0);
        send_frame(8'h11, 1'b0, 11, 1'b1);
        chk_ovf("t5b_ovf", 1'b0);
        chk_byte("t5b_head", 8'h02);
        for (int i = 2; i <= 17; i++) begin
            chk_byte("t5b_drain_byte", 8'(i));
            do_pop();
        end
        chk_retry("t5b_empty", 1'b1);
        chk_ovf("t5b_ovf_end", 1'b0);

        // reset mid-frame with 3 bytes queued
        do_reset();
        send_frame(8'h0A, 1'b0, 11, 1'b0);
        send_frame(8'h0B, 1'b0, 11, 1'b0);
        send_frame(8'h0C, 1'b0, 11, 1'b0);
        chk_byte("t6_head", 8'h0A);
        send_frame(8'h76, 1'b0, 4, 1'b0);
        @(negedge clk);
        rst_n_in = 1'b0;
        #1;
        check("t6_reset_q", pop_if.pop_q, {1'b1, 32'h0});
        ps2_dat_in = 1'b1;
        wait_cyc(3);
        rst_n_in = 1'b1;
        wait_cyc(20);
        send_frame(8'h76, 1'b0, 11, 1'b0);
        chk_retry("t6_retry", 1'b0);
        chk_byte("t6_byte", 8'h76);
        chk_err("t6_err", 8'd0);
        do_pop();
        chk_retry("t6_empty", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
